wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 64-bit result bus between 8 requesters (FUs/LSU ports).
//  Drives the 3-bit select of the 64-bit 8:1 bus mux (instantiated inside as the datapath).
//  Supports locked bursts and valid/ready backpressure toward the writeback stage.
// PARAMETERS
//  N_REQ      8    requester count; fixed at 8 (select is 3 bits)
//  WIDTH      64   data width per requester
//  MAX_BURST  4    max beats a locked requester may hold the bus (1..15)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          async active-low reset
//  req        in   8          req[i]: requester i has a valid beat on in_data[i]
//  lock       in   8          lock[i]: requester i wants to keep the bus after the current beat
//  in_data    in   8x64       per-requester data, [7:0][63:0] packed
//  ack        out  8          one-hot; ack[i]=1 on the cycle requester i's beat is taken
//  out_valid  out  1          beat on out_data is valid
//  out_ready  in   1          downstream accepts beat when out_valid & out_ready
//  out_data   out  64         in_data[sel]
//  out_src    out  3          index of the current owner (= mux select)
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, rr_ptr=0, burst_cnt=0; out_valid=0, ack=0, out_src=0, out_data=in_data[0].
//  States: IDLE (no owner), GRANT (owner holds one beat), LOCK (owner in burst).
//  Arbitration (IDLE, or GRANT/LOCK on handoff): pick the first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod 8.
//  The grant is registered: a req seen in cycle N -> sel/out_src updated, out_valid=1 in N+1 (1-cycle latency).
//  out_valid = (state!=IDLE) & req[sel]; out_data/out_src combinational from the registered sel.
//  ack[sel] = out_valid & out_ready; other ack bits 0. A requester must hold req and in_data stable until acked.
//  Stall (out_valid & !out_ready): sel, state, burst_cnt held; no re-arbitration.
//  On a beat transfer from owner s:
//   - lock[s]=1 and burst_cnt<MAX_BURST-1 -> LOCK, burst_cnt++, sel unchanged.
//   - else -> rr_ptr=s+1 (wraps 7->0), burst_cnt=0, re-arbitrate the same cycle; next owner valid next cycle
//     (back-to-back beats, no bubble); no req pending -> IDLE.
//  Owner s may take a new grant right after release only if no other requester is pending (fairness).
//  A locked owner that drops req in LOCK: release, burst_cnt=0, re-arbitrate (no hang).
//  Burst cap: the MAX_BURST-th beat forces release regardless of lock.
//  Requests are ignored when nothing is pending; all 8 pending -> strict rotation 0,1,...,7,0.
//  rst_n low at any time: immediate return to reset values, including mid-burst; no beat is acked.
// CONFIGURATION
//  `WB_ARB_STATS_EN defined: adds output port grant_cnt [7:0][15:0]; grant_cnt[i] increments on each ack[i],
//   saturates at 16'hFFFF, resets to 0 on rst_n.
//  Not defined: the port and counters are absent; arbitration is identical.
// STRUCTURE
//  Package wb_arb_pkg: N_REQ, SEL_W=3, typedef enum logic [1:0] {IDLE, GRANT, LOCK} arb_state_t,
//   typedef logic [7:0][63:0] req_data_t.
//  Sub-module rr_pick8: combinational round-robin priority encoder (req[7:0], ptr[2:0] -> found, idx[2:0]).
//  Datapath: reuse the existing 64-bit 8:1 mux for out_data; the arbiter owns only control.
// TESTING
//  1 Reset: rst_n=0 with req=8'hFF -> out_valid=0, ack=0, out_src=0; release -> owner 0 valid on the next cycle.
//  2 Rotation: req=8'hFF held, lock=0, out_ready=1 -> out_src 0,1,...,7,0; one ack per cycle, no bubbles;
//    out_data = in_data[out_src] (in_data[i]=64'h1111_1111_1111_1111*i).
//  3 Stall: owner 3 valid, out_ready=0 for 5 cycles, req[5] raised -> out_src stays 3, ack=0;
//    out_ready=1 -> ack=8'h08, then owner 5.
//  4 Burst: lock[2]=1, req=8'h24, MAX_BURST=4 -> 4 consecutive acks to 2, forced release, owner 5 next.
//  5 Early release: lock[6]=1, req[6] dropped after 2 beats -> LOCK exits, next pending owner granted; IDLE if none.
//  6 Reset mid-burst: rst_n pulsed low during a LOCK beat -> outputs at reset values asynchronously; rr_ptr=0 afterwards.
//  With `WB_ARB_STATS_EN: after test 2 (16 beats), grant_cnt[i]=2 for all i; saturation checked by force-preloading 16'hFFFE.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback result-bus arbiter.
package wb_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCK
  } arb_state_t;

  typedef logic [N_REQ-1:0][WIDTH-1:0] req_data_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr, wrapping mod 8.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] w_cand;

  // Scan from farthest to nearest so the nearest candidate wins the last assignment
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int k = 7; k >= 0; k--) begin
      w_cand = ptr + 3'(k);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for the shared 64-bit writeback result bus, with locked bursts and
// valid/ready backpressure. Optional per-requester grant counters are enabled by defining
// WB_ARB_STATS_EN (adds the grant_cnt output).
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      lock,
  input  req_data_t             in_data,
  output logic [N_REQ-1:0]      ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src
`ifdef WB_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0] grant_cnt
`endif
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  arb_state_t       r_state, w_state_d;
  logic [SEL_W-1:0] r_sel, w_sel_d;
  logic [SEL_W-1:0] r_rr_ptr, w_rr_ptr_d;
  logic [3:0]       r_burst_cnt, w_burst_cnt_d;
  logic [SEL_W-1:0] w_pick_ptr, w_pick_idx;
  logic             w_pick_found, w_xfer, w_extend, w_release;

  // On handoff the scan starts just past the outgoing owner so it ranks last
  assign w_pick_ptr = (r_state == IDLE) ? r_rr_ptr : r_sel + 3'd1;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  assign out_valid = (r_state != IDLE) & req[r_sel];
  assign w_xfer    = out_valid & out_ready;
  assign w_extend  = lock[r_sel] & (r_burst_cnt < BURST_LAST);
  // Owner dropped its request, or its final beat (single or burst cap) just transferred
  assign w_release = (r_state != IDLE) & (~req[r_sel] | (w_xfer & ~w_extend));

  // Datapath: 64-bit 8:1 result mux driven by the registered select
  assign out_data = in_data[r_sel];
  assign out_src  = r_sel;
  assign ack      = w_xfer ? (N_REQ'(1) << r_sel) : '0;

  // Next-state: arbitrate from IDLE or on release, extend a burst, otherwise hold (stall)
  always_comb begin
    w_state_d     = r_state;
    w_sel_d       = r_sel;
    w_rr_ptr_d    = r_rr_ptr;
    w_burst_cnt_d = r_burst_cnt;
    if (r_state == IDLE) begin
      if (w_pick_found) begin
        w_state_d = GRANT;
        w_sel_d   = w_pick_idx;
      end
    end else if (w_release) begin
      w_rr_ptr_d    = r_sel + 3'd1;
      w_burst_cnt_d = '0;
      if (w_pick_found) begin
        w_state_d = GRANT;
        w_sel_d   = w_pick_idx;
      end else begin
        w_state_d = IDLE;
      end
    end else if (w_xfer) begin
      w_state_d     = LOCK;
      w_burst_cnt_d = r_burst_cnt + 4'd1;
    end
  end

  // Arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_sel       <= w_sel_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_burst_cnt <= w_burst_cnt_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] r_grant_cnt;

  // Saturating per-requester count of accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ack[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus random traffic, all
// compared against a behavioural owner/queue model.
module tb_wb_bus_arbiter;
  import wb_arb_pkg::*;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req, lock, ack;
  req_data_t   in_data;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_src;
`ifdef WB_ARB_STATS_EN
  logic [7:0][15:0] grant_cnt;
`endif

  wb_bus_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .in_data   (in_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef WB_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus (-1 = nobody), beats already moved this tenure, rotation start.
  int m_owner, m_sel, m_beats, m_ptr;
  int m_cnt[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_sel   = 0;
    m_beats = 0;
    m_ptr   = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  function automatic bit exp_valid();
    return (m_owner >= 0) && (req[m_owner] === 1'b1);
  endfunction

  task automatic check_outputs(input string tag);
    logic [7:0] e_ack;
    e_ack = 8'h00;
    if (exp_valid() && out_ready) e_ack[m_owner] = 1'b1;
    chk({tag, ".valid"}, 64'(out_valid), 64'(exp_valid()));
    chk({tag, ".ack"}, 64'(ack), 64'(e_ack));
    if (exp_valid()) begin
      chk({tag, ".src"}, 64'(out_src), 64'(m_sel));
      chk({tag, ".data"}, out_data, in_data[m_sel]);
    end
`ifdef WB_ARB_STATS_EN
    for (int i = 0; i < 8; i++) chk({tag, ".cnt"}, 64'(grant_cnt[i]), 64'(m_cnt[i]));
`endif
  endtask

  task automatic model_handoff(input int from);
    int p;
    m_ptr   = (from + 1) % 8;
    m_beats = 0;
    p       = pick(req, m_ptr);
    m_owner = p;
    if (p >= 0) m_sel = p;
  endtask

  task automatic model_step();
    int p;
    if (m_owner < 0) begin
      p = pick(req, m_ptr);
      if (p >= 0) begin
        m_owner = p;
        m_sel   = p;
      end
    end else if (!req[m_owner]) begin
      model_handoff(m_owner);
    end else if (out_ready) begin
      if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
      if (lock[m_owner] && (m_beats + 1 < MAXB)) m_beats++;
      else model_handoff(m_owner);
    end
  endtask

  task automatic settle(input string tag);
    #3;
    check_outputs(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ack", 64'(ack), 64'd0);
    chk("rst.src", 64'(out_src), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 8'hFF;
    lock      = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i] = 64'h1111_1111_1111_1111 * 64'(i);

    // 1: reset with all requesting, owner 0 one cycle after release
    do_reset();
    settle("t1.idle");
    chk("t1.novalid", 64'(out_valid), 64'd0);
    tick();
    settle("t1.first");
    chk("t1.owner0", 64'(out_src), 64'd0);

    // 2: strict rotation over 16 back-to-back beats
    do_reset();
    settle("t2.idle");
    tick();
    for (int i = 0; i < 16; i++) begin
      settle("t2.rot");
      chk("t2.src", 64'(out_src), 64'(i % 8));
      chk("t2.ack", 64'(ack), 64'(8'h01 << (i % 8)));
      chk("t2.data", out_data, 64'h1111_1111_1111_1111 * 64'(i % 8));
      tick();
    end
`ifdef WB_ARB_STATS_EN
    for (int i = 0; i < 8; i++) chk("t2.gcnt", 64'(grant_cnt[i]), 64'd2);
`endif

    // 3: stall holds owner 3 while 5 waits
    do_reset();
    req = 8'h08;
    settle("t3.idle");
    tick();
    req       = 8'h28;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle("t3.stall");
      chk("t3.hold", 64'(out_src), 64'd3);
      chk("t3.noack", 64'(ack), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    settle("t3.go");
    chk("t3.ack3", 64'(ack), 64'h08);
    tick();
    settle("t3.next");
    chk("t3.owner5", 64'(out_src), 64'd5);
    tick();

    // 4: locked burst capped at MAX_BURST beats, then 5 takes over
    do_reset();
    req  = 8'h24;
    lock = 8'h04;
    settle("t4.idle");
    tick();
    for (int i = 0; i < MAXB; i++) begin
      settle("t4.burst");
      chk("t4.ack2", 64'(ack), 64'h04);
      tick();
    end
    settle("t4.after");
    chk("t4.owner5", 64'(out_src), 64'd5);
    chk("t4.ack5", 64'(ack), 64'h20);
    tick();

    // 5: locked owner drops req after 2 beats; 3 pending, then nothing
    do_reset();
    req  = 8'h40;
    lock = 8'h40;
    settle("t5.idle");
    tick();
    for (int i = 0; i < 2; i++) begin
      settle("t5.beat");
      chk("t5.ack6", 64'(ack), 64'h40);
      tick();
    end
    req = 8'h08;
    settle("t5.drop");
    chk("t5.gone", 64'(out_valid), 64'd0);
    tick();
    settle("t5.new");
    chk("t5.owner3", 64'(out_src), 64'd3);
    tick();
    req = 8'h00;
    settle("t5.empty");
    tick();
    settle("t5.idle2");
    chk("t5.novalid", 64'(out_valid), 64'd0);
    tick();

    // 6: asynchronous reset in the middle of a locked burst
    do_reset();
    req  = 8'h04;
    lock = 8'h04;
    settle("t6.idle");
    tick();
    settle("t6.beat1");
    tick();
    settle("t6.beat2");
    chk("t6.src2", 64'(out_src), 64'd2);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6.async_valid", 64'(out_valid), 64'd0);
    chk("t6.async_ack", 64'(ack), 64'd0);
    chk("t6.async_src", 64'(out_src), 64'd0);
    @(posedge clk);
    #1;
    req   = 8'hFF;
    lock  = 8'h00;
    rst_n = 1'b1;
    settle("t6.idle2");
    tick();
    settle("t6.ptr0");
    chk("t6.owner0", 64'(out_src), 64'd0);
    tick();

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req       = 8'($urandom) & 8'($urandom);
      lock      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) in_data[i] = {$urandom, $urandom};
      settle("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
